// File: rtl/dac_spi_multi_driver.sv
// Multi-channel SPI DAC write engine: CH_NUM mode-0 frames, then one shared ld_n strobe.
// Optional per-channel skip mask when DAC_SPI_CH_MASK_EN is defined.
module dac_spi_multi_driver #(
  parameter int DATA_W   = 16,
  parameter int CH_NUM   = 2,
  parameter int SCK_HALF = 2,
  parameter int GAP_CYC  = 4,
  parameter int LDAC_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
`ifdef DAC_SPI_CH_MASK_EN
  input  logic [CH_NUM-1:0]        ch_mask,
`endif
  input  logic [CH_NUM*DATA_W-1:0] data,
  output logic                     busy,
  output logic                     done,
  output logic                     cs_n,
  output logic                     sck,
  output logic                     sdi,
  output logic                     ld_n
);

  // state | meaning
  // IDLE  | waiting for start
  // SETUP | cs_n low, first bit on sdi, SCK_HALF cycles
  // SHIFT | DATA_W sck periods; hi marks the high half
  // GAP   | cs_n high GAP_CYC cycles, then next channel or LDAC
  // LDAC  | ld_n low LDAC_W cycles
  // DONE  | one-cycle completion

  localparam int BW = $clog2(DATA_W + 1);
  localparam int CW = $clog2(CH_NUM + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, LDAC, DONE} state_t;

  state_t              state, state_nx;
  logic [7:0]          phase, phase_nx;
  logic [BW-1:0]       bit_cnt, bit_cnt_nx;
  logic [CW-1:0]       ch_idx, ch_idx_nx;
  logic                hi, hi_nx;
  logic                sent, sent_nx;
  logic [DATA_W-1:0]   sreg, sreg_nx;
  logic [CH_NUM*DATA_W-1:0] data_q, data_src;
  logic [CH_NUM-1:0]   mask_in, mask_q, mask_src;
  logic                accept;
  logic                nxt_found;
  logic [CW-1:0]       nxt_idx;
  logic [DATA_W-1:0]   nxt_word;
  int                  from_i;
  logic                cs_n_nx, sck_nx, sdi_nx, ld_n_nx, done_nx;

`ifdef DAC_SPI_CH_MASK_EN
  assign mask_in = ch_mask;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mask_q <= '0;
    else if (accept) mask_q <= mask_in;
  end
`else
  assign mask_in = '1;
  assign mask_q  = '1;
`endif

  assign accept = (state == IDLE) && start && !busy;

  // In IDLE the search runs on the live inputs so the first frame is loaded on the accept edge
  assign mask_src = (state == IDLE) ? mask_in : mask_q;
  assign data_src = (state == IDLE) ? data : data_q;

  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    from_i    = (state == IDLE) ? 0 : int'(ch_idx) + 1;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (mask_src[i] && (i >= from_i)) begin
        nxt_found = 1'b1;
        nxt_idx   = CW'(i);
      end
    end
  end

  assign nxt_word = data_src[int'(nxt_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_nx   = state;
    phase_nx   = phase;
    bit_cnt_nx = bit_cnt;
    ch_idx_nx  = ch_idx;
    hi_nx      = hi;
    sent_nx    = sent;
    sreg_nx    = sreg;
    case (state)
      IDLE: begin
        if (accept) begin
          ch_idx_nx = '0;
          if (nxt_found) begin
            state_nx  = SETUP;
            ch_idx_nx = nxt_idx;
            phase_nx  = 8'(SCK_HALF - 1);
            sreg_nx   = nxt_word;
            sent_nx   = 1'b1;
          end else begin
            // empty mask: one idle GAP cycle keeps done two cycles after start
            state_nx = GAP;
            phase_nx = '0;
            sent_nx  = 1'b0;
          end
        end
      end
      SETUP: begin
        if (phase == 8'd0) begin
          state_nx   = SHIFT;
          hi_nx      = 1'b1;
          phase_nx   = 8'(SCK_HALF - 1);
          bit_cnt_nx = BW'(DATA_W - 1);
        end else begin
          phase_nx = phase - 8'd1;
        end
      end
      SHIFT: begin
        if (phase != 8'd0) begin
          phase_nx = phase - 8'd1;
        end else if (hi) begin
          hi_nx    = 1'b0;
          phase_nx = 8'(SCK_HALF - 1);
          sreg_nx  = {sreg[DATA_W-2:0], 1'b0};
        end else if (bit_cnt == '0) begin
          state_nx = GAP;
          phase_nx = 8'(GAP_CYC - 1);
        end else begin
          bit_cnt_nx = bit_cnt - 1'b1;
          hi_nx      = 1'b1;
          phase_nx   = 8'(SCK_HALF - 1);
        end
      end
      GAP: begin
        if (phase != 8'd0) begin
          phase_nx = phase - 8'd1;
        end else if (nxt_found) begin
          state_nx  = SETUP;
          ch_idx_nx = nxt_idx;
          phase_nx  = 8'(SCK_HALF - 1);
          sreg_nx   = nxt_word;
          sent_nx   = 1'b1;
        end else begin
          ch_idx_nx = '0;
          if (sent) begin
            state_nx = LDAC;
            phase_nx = 8'(LDAC_W - 1);
          end else begin
            state_nx = DONE;
          end
        end
      end
      LDAC: begin
        if (phase == 8'd0) state_nx = DONE;
        else               phase_nx = phase - 8'd1;
      end
      DONE: begin
        state_nx = IDLE;
        sent_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pin values are decoded from the current state and registered, giving a uniform one-cycle lag
  always_comb begin
    cs_n_nx = !((state == SETUP) || (state == SHIFT));
    sck_nx  = (state == SHIFT) && hi;
    sdi_nx  = ((state == SETUP) || (state == SHIFT)) && sreg[DATA_W-1];
    ld_n_nx = (state != LDAC);
    done_nx = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      ch_idx  <= '0;
      hi      <= 1'b0;
      sent    <= 1'b0;
      sreg    <= '0;
      data_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      sdi     <= 1'b0;
      ld_n    <= 1'b1;
    end else begin
      state   <= state_nx;
      phase   <= phase_nx;
      bit_cnt <= bit_cnt_nx;
      ch_idx  <= ch_idx_nx;
      hi      <= hi_nx;
      sent    <= sent_nx;
      sreg    <= sreg_nx;
      if (accept) data_q <= data;
      if (accept)              busy <= 1'b1;
      else if (state == IDLE)  busy <= 1'b0;
      done    <= done_nx;
      cs_n    <= cs_n_nx;
      sck     <= sck_nx;
      sdi     <= sdi_nx;
      ld_n    <= ld_n_nx;
    end
  end

endmodule

// File: tb/tb_dac_spi_multi_driver.sv
// Self-checking bench for dac_spi_multi_driver; frames are decoded from the pins and
// compared with words/timings derived from the channel list. Mask cases need DAC_SPI_CH_MASK_EN.
module tb_dac_spi_multi_driver;

  localparam int GAP = 4;
  localparam int LDW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        st1 = 1'b0, st2 = 1'b0;
  logic [31:0] d1 = '0;
  logic [23:0] d2 = '0;
  logic busy1, done1, cs1, sck1, sdi1, ld1;
  logic busy2, done2, cs2, sck2, sdi2, ld2;

  dac_spi_multi_driver u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1),
`ifdef DAC_SPI_CH_MASK_EN
    .ch_mask(2'b11),
`endif
    .data(d1), .busy(busy1), .done(done1), .cs_n(cs1), .sck(sck1), .sdi(sdi1), .ld_n(ld1));

  dac_spi_multi_driver #(.DATA_W(24), .CH_NUM(1), .SCK_HALF(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2),
`ifdef DAC_SPI_CH_MASK_EN
    .ch_mask(1'b1),
`endif
    .data(d2), .busy(busy2), .done(done2), .cs_n(cs2), .sck(sck2), .sdi(sdi2), .ld_n(ld2));

`ifdef DAC_SPI_CH_MASK_EN
  logic        st3 = 1'b0;
  logic [63:0] d3 = '0;
  logic [3:0]  m3 = '0;
  logic busy3, done3, cs3, sck3, sdi3, ld3;
  dac_spi_multi_driver #(.CH_NUM(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .ch_mask(m3),
    .data(d3), .busy(busy3), .done(done3), .cs_n(cs3), .sck(sck3), .sdi(sdi3), .ld_n(ld3));
`endif

  int dsel = 0;
  logic o_busy, o_done, o_cs, o_sck, o_sdi, o_ld;
  always_comb begin
    {o_busy, o_done, o_cs, o_sck, o_sdi, o_ld} = {busy1, done1, cs1, sck1, sdi1, ld1};
    if (dsel == 1) {o_busy, o_done, o_cs, o_sck, o_sdi, o_ld} = {busy2, done2, cs2, sck2, sdi2, ld2};
`ifdef DAC_SPI_CH_MASK_EN
    if (dsel == 2) {o_busy, o_done, o_cs, o_sck, o_sdi, o_ld} = {busy3, done3, cs3, sck3, sdi3, ld3};
`endif
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) st1 = v;
    else if (s == 1) st2 = v;
`ifdef DAC_SPI_CH_MASK_EN
    else st3 = v;
`endif
  endtask

  // Call right after a negedge. Runs one transaction on DUT s and checks pins against the
  // channel list; inj1/inj2 re-pulse start (with data zeroed) at those sample cycles.
  task automatic txn(input int s, input int dw, input int ch, input int sh,
                     input logic [7:0] mask, input logic [63:0] dv,
                     input int inj1, input int inj2);
    logic [63:0] q[$];
    logic [63:0] wm, word, expw;
    int n, lat, lowcnt, edges, frames, ldp, ldstart, ldlen, dcnt, dk, sck_bad;
    logic prev_cs, prev_sck, prev_ld;
    string tg;
    wm = (64'd1 << dw) - 64'd1;
    for (int c = 0; c < ch; c++)
      if (mask[c]) q.push_back((dv >> (c*dw)) & wm);
    n   = q.size();
    lat = (n == 0) ? 2 : 1 + n*(sh*(1 + 2*dw) + GAP) + LDW;
    dsel = s;
    if (s == 0) d1 = dv[31:0];
    else if (s == 1) d2 = dv[23:0];
`ifdef DAC_SPI_CH_MASK_EN
    else begin d3 = dv; m3 = mask[3:0]; end
`endif
    set_start(s, 1'b1);
    @(posedge clk);
    prev_cs = 1'b1; prev_sck = 1'b0; prev_ld = 1'b1;
    lowcnt = 0; edges = 0; frames = 0; ldp = 0; ldstart = -1; ldlen = 0;
    dcnt = 0; dk = -1; sck_bad = 0; word = '0;
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      tg = $sformatf("dut%0d_k%0d", s, k);
      if (k == 0) chk({tg, "_cs_idle"}, o_cs, 1'b1);
      if (k == 1 && n > 0) chk({tg, "_cs_fall"}, o_cs, 1'b0);
      if (prev_cs && !o_cs) begin lowcnt = 0; edges = 0; word = '0; end
      if (!o_cs) begin
        lowcnt++;
        if (!prev_sck && o_sck) begin word = (word << 1) | 64'(o_sdi); edges++; end
      end
      if (o_cs && o_sck) sck_bad++;
      if (!prev_cs && o_cs) begin
        expw = (q.size() > 0) ? q.pop_front() : 64'hdead;
        chk($sformatf("dut%0d_frame%0d_word", s, frames), word, expw);
        chk($sformatf("dut%0d_frame%0d_edges", s, frames), 64'(edges), 64'(dw));
        chk($sformatf("dut%0d_frame%0d_cslow", s, frames), 64'(lowcnt), 64'(sh*(1 + 2*dw)));
        frames++;
      end
      if (!o_ld) begin
        if (prev_ld) begin ldp++; ldstart = k; ldlen = 0; end
        ldlen++;
      end
      if (o_done) begin dcnt++; dk = k; end
      if (k == lat)     chk({tg, "_busy_at_done"}, o_busy, 1'b1);
      if (k == lat + 1) chk({tg, "_busy_after"}, o_busy, 1'b0);
      prev_cs = o_cs; prev_sck = o_sck; prev_ld = o_ld;
      if (k == 0) set_start(s, 1'b0);
      if (k == inj1 || k == inj2) begin
        set_start(s, 1'b1);
        if (s == 0) d1 = '0; else if (s == 1) d2 = '0;
`ifdef DAC_SPI_CH_MASK_EN
        else d3 = '0;
`endif
      end else if (k == inj1 + 1 || k == inj2 + 1) begin
        set_start(s, 1'b0);
      end
    end
    chk($sformatf("dut%0d_frames", s), 64'(frames), 64'(n));
    chk($sformatf("dut%0d_done_count", s), 64'(dcnt), 64'd1);
    chk($sformatf("dut%0d_done_cycle", s), 64'(dk), 64'(lat));
    chk($sformatf("dut%0d_ld_pulses", s), 64'(ldp), (n > 0) ? 64'd1 : 64'd0);
    if (n > 0) begin
      chk($sformatf("dut%0d_ld_len", s), 64'(ldlen), 64'(LDW));
      chk($sformatf("dut%0d_ld_start", s), 64'(ldstart), 64'(lat - LDW));
    end
    chk($sformatf("dut%0d_sck_outside_cs", s), 64'(sck_bad), 64'd0);
  endtask

  task automatic chk_reset1(input string tg);
    chk({tg, "_cs_n"}, cs1, 1'b1);
    chk({tg, "_sck"},  sck1, 1'b0);
    chk({tg, "_sdi"},  sdi1, 1'b0);
    chk({tg, "_ld_n"}, ld1, 1'b1);
    chk({tg, "_busy"}, busy1, 1'b0);
    chk({tg, "_done"}, done1, 1'b0);
  endtask

  localparam int LAT_DEF = 1 + 2*(2*(1 + 2*16) + GAP) + LDW;

  initial begin
    repeat (3) @(negedge clk);
    chk_reset1("rst_dut1");
    chk("rst_dut2_cs_n", cs2, 1'b1);
    chk("rst_dut2_ld_n", ld2, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    txn(0, 16, 2, 2, 8'h03, 64'h9ABC_3123, -1, -1);
    txn(0, 16, 2, 2, 8'h03, {32'd0, $urandom()}, 20, 100);
    // start during the done cycle is ignored; the next txn starts one cycle later, back to back
    txn(0, 16, 2, 2, 8'h03, {32'd0, $urandom()}, LAT_DEF, -1);
    txn(0, 16, 2, 2, 8'h03, {32'd0, $urandom()}, -1, -1);

    @(negedge clk);
    txn(1, 24, 1, 1, 8'h01, 64'hA5F00F, -1, -1);
    for (int r = 0; r < 3; r++) txn(1, 24, 1, 1, 8'h01, {40'd0, 24'($urandom())}, -1, -1);

    // asynchronous reset mid-frame
    dsel = 0;
    d1 = $urandom();
    st1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st1 = 1'b0;
    repeat (39) @(negedge clk);
    chk("pre_reset_cs_low", cs1, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_reset1("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(0, 16, 2, 2, 8'h03, {32'd0, $urandom()}, -1, -1);

`ifdef DAC_SPI_CH_MASK_EN
    @(negedge clk);
    txn(2, 16, 4, 2, 8'b1010, {$urandom(), $urandom()}, -1, -1);
    txn(2, 16, 4, 2, 8'b0000, {$urandom(), $urandom()}, -1, -1);
    txn(2, 16, 4, 2, 8'($urandom_range(1, 15)), {$urandom(), $urandom()}, -1, -1);
    txn(2, 16, 4, 2, 8'b1111, {$urandom(), $urandom()}, -1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
